iiq_issue_select: RTL and testbench



---
 rtl/iiq_issue_select_if.sv | 37 +++
 rtl/iiq_issue_select.sv | 94 +++++++++
 tb/tb_iiq_issue_select.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/iiq_issue_select_if.sv
// Bundle between the issue-queue slots, the select/wakeup logic and the ALU issue port.
// The design uses the master modport; the queue/ALU side (or a bench) uses slave.
`ifndef IIQ_N_ENTRIES
`define IIQ_N_ENTRIES 8
`endif

interface iiq_issue_select_if #(
    parameter int N_ENTRIES     = `IIQ_N_ENTRIES,
    parameter int TAG_WIDTH     = 6,
    parameter int PAYLOAD_WIDTH = 32
);
    localparam int ENTRY_WIDTH = 3 * TAG_WIDTH + 2 + PAYLOAD_WIDTH;

    logic [N_ENTRIES-1:0]                  entry_valid;
    logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] entry_douts;
    logic                                  wb_valid;
    logic [TAG_WIDTH-1:0]                  wb_tag;
    logic                                  flush;
    logic                                  deq_ready;
    logic [N_ENTRIES-1:0]                  deq_sel_onehot;
    logic [N_ENTRIES-1:0]                  wr_en;
    logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] wr_data;
    logic                                  iss_valid;
    logic [ENTRY_WIDTH-1:0]                iss_data;
    logic                                  iss_ready;
    logic [15:0]                           stall_cnt;

    modport master (
        input  entry_valid, entry_douts, wb_valid, wb_tag, flush, iss_ready,
        output deq_ready, deq_sel_onehot, wr_en, wr_data, iss_valid, iss_data, stall_cnt
    );

    modport slave (
        output entry_valid, entry_douts, wb_valid, wb_tag, flush, iss_ready,
        input  deq_ready, deq_sel_onehot, wr_en, wr_data, iss_valid, iss_data, stall_cnt
    );
endinterface

// File: rtl/iiq_issue_select.sv
// Oldest-first issue select with tag-broadcast wakeup and a single-entry issue register.
// Eligibility uses only stored ready bits, so a wakeup takes one extra cycle to reach issue.
`ifndef IIQ_N_ENTRIES
`define IIQ_N_ENTRIES 8
`endif

module iiq_issue_select #(
    parameter int N_ENTRIES     = `IIQ_N_ENTRIES,
    parameter int TAG_WIDTH     = 6,
    parameter int PAYLOAD_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_aL,
    iiq_issue_select_if.master  bus
);
    localparam int ENTRY_WIDTH = 3 * TAG_WIDTH + 2 + PAYLOAD_WIDTH;
    localparam int S1_RDY      = TAG_WIDTH;
    localparam int S2_LSB      = TAG_WIDTH + 1;
    localparam int S2_RDY      = 2 * TAG_WIDTH + 1;

    logic [N_ENTRIES-1:0] eligible;
    logic [N_ENTRIES-1:0] sel;
    logic                 any_eligible;
    logic                 can_issue;
    logic                 deq_ready;
    logic                 iss_valid;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        eligible = '0;
        sel      = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            eligible[i] = bus.entry_valid[i] & bus.entry_douts[i][S1_RDY]
                        & bus.entry_douts[i][S2_RDY];
        end
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (eligible[i]) sel = N_ENTRIES'(1) << i;
        end
    end

    assign any_eligible = |eligible;
    assign can_issue    = !iss_valid || bus.iss_ready;
    assign deq_ready    = rst_aL && any_eligible && can_issue && !bus.flush;

    assign bus.deq_ready      = deq_ready;
    assign bus.deq_sel_onehot = deq_ready ? sel : '0;
    assign bus.iss_valid      = iss_valid;

    // Wakeup only sets ready bits the queue has not stored yet; the dequeued slot is left alone.
    always_comb begin
        bus.wr_en   = '0;
        bus.wr_data = bus.entry_douts;
        for (int i = 0; i < N_ENTRIES; i++) begin
            logic m1, m2;
            m1 = bus.entry_valid[i] && bus.wb_valid && !bus.entry_douts[i][S1_RDY]
              && (bus.entry_douts[i][TAG_WIDTH-1:0] == bus.wb_tag);
            m2 = bus.entry_valid[i] && bus.wb_valid && !bus.entry_douts[i][S2_RDY]
              && (bus.entry_douts[i][S2_RDY-1:S2_LSB] == bus.wb_tag);
            if (rst_aL && !bus.flush && !bus.deq_sel_onehot[i] && (m1 || m2)) begin
                bus.wr_en[i] = 1'b1;
                if (m1) bus.wr_data[i][S1_RDY] = 1'b1;
                if (m2) bus.wr_data[i][S2_RDY] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            iss_valid     <= 1'b0;
            bus.iss_data  <= '0;
            bus.stall_cnt <= '0;
        end else begin
            if (bus.flush) begin
                iss_valid <= 1'b0;
            end else if (deq_ready) begin
                iss_valid    <= 1'b1;
                bus.iss_data <= bus.entry_douts[$clog2(N_ENTRIES)'(idx_of(sel))];
            end else if (iss_valid && bus.iss_ready) begin
                iss_valid <= 1'b0;
            end
            if (any_eligible && !can_issue && !bus.flush && bus.stall_cnt != 16'hFFFF) begin
                bus.stall_cnt <= bus.stall_cnt + 16'd1;
            end
        end
    end

    function automatic int idx_of(input logic [N_ENTRIES-1:0] onehot);
        idx_of = 0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (onehot[i]) idx_of = i;
        end
    endfunction
endmodule

// File: tb/tb_iiq_issue_select.sv
// Directed bench for iiq_issue_select: select priority, wakeup, stall, back-to-back, flush, reset.
module tb_iiq_issue_select;
    localparam int N  = 8;
    localparam int TW = 6;
    localparam int PW = 32;
    localparam int EW = 3 * TW + 2 + PW;

    logic clk = 1'b0;
    logic rst_aL;
    int   checks = 0;
    int   errors = 0;

    iiq_issue_select_if #(.N_ENTRIES(N), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW)) bus ();

    iiq_issue_select #(.N_ENTRIES(N), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW)) dut (
        .clk    (clk),
        .rst_aL (rst_aL),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] mk(input logic [TW-1:0] s1, input logic r1,
                                         input logic [TW-1:0] s2, input logic r2,
                                         input logic [TW-1:0] dst, input logic [PW-1:0] pl);
        return {pl, dst, r2, s2, r1, s1};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_slots();
        bus.entry_valid = '0;
        bus.entry_douts = '0;
        bus.wb_valid    = 1'b0;
        bus.wb_tag      = '0;
    endtask

    logic [EW-1:0] q [4];
    logic [EW-1:0] e0, e1, e2, x_ent;

    initial begin
        // Reset with an eligible slot and a matching broadcast: everything stays quiet.
        rst_aL        = 1'b0;
        bus.flush     = 1'b0;
        bus.iss_ready = 1'b1;
        clear_slots();
        bus.entry_valid    = 8'b0000_0011;
        bus.entry_douts[0] = mk(6'h01, 1, 6'h02, 1, 6'h10, 32'hAAAA_0000);
        bus.entry_douts[1] = mk(6'h05, 0, 6'h02, 1, 6'h11, 32'hAAAA_0001);
        bus.wb_valid       = 1'b1;
        bus.wb_tag         = 6'h05;
        #1;
        check("rst_deq_ready", 64'(bus.deq_ready), 64'd0);
        check("rst_deq_sel", 64'(bus.deq_sel_onehot), 64'd0);
        check("rst_wr_en", 64'(bus.wr_en), 64'd0);
        repeat (2) tick();
        check("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
        check("rst_iss_data", 64'(bus.iss_data), 64'd0);
        check("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        rst_aL = 1'b1;

        // Slot 0 blocked on src2, slot 1 fully ready: slot 1 goes first.
        clear_slots();
        e0 = mk(6'h01, 1, 6'h02, 0, 6'h10, 32'h1111_0000);
        e1 = mk(6'h03, 1, 6'h04, 1, 6'h11, 32'h1111_0001);
        bus.entry_valid    = 8'b0000_0011;
        bus.entry_douts[0] = e0;
        bus.entry_douts[1] = e1;
        #1;
        check("sel_skip_deq_ready", 64'(bus.deq_ready), 64'd1);
        check("sel_skip_onehot", 64'(bus.deq_sel_onehot), 64'h02);
        tick();
        check("sel_skip_iss_valid", 64'(bus.iss_valid), 64'd1);
        check("sel_skip_iss_data", 64'(bus.iss_data), 64'(e1));
        bus.entry_valid    = 8'b0000_0001;
        bus.entry_douts[1] = '0;
        #1;
        check("sel_skip_none_left", 64'(bus.deq_ready), 64'd0);
        tick();
        check("drain_iss_valid", 64'(bus.iss_valid), 64'd0);
        check("drain_iss_data_hold", 64'(bus.iss_data), 64'(e1));

        // Wakeup of src1: write-back this cycle, eligible next, issued the one after.
        clear_slots();
        e0 = mk(6'h05, 0, 6'h07, 1, 6'h12, 32'h2222_0000);
        bus.entry_valid    = 8'b0000_0001;
        bus.entry_douts[0] = e0;
        bus.wb_valid       = 1'b1;
        bus.wb_tag         = 6'h05;
        #1;
        check("wake_wr_en", 64'(bus.wr_en), 64'h01);
        check("wake_wr_data", 64'(bus.wr_data[0]), 64'(mk(6'h05, 1, 6'h07, 1, 6'h12, 32'h2222_0000)));
        check("wake_deq_ready", 64'(bus.deq_ready), 64'd0);
        tick();
        bus.wb_valid       = 1'b0;
        bus.entry_douts[0] = mk(6'h05, 1, 6'h07, 1, 6'h12, 32'h2222_0000);
        #1;
        check("wake_t1_iss_valid", 64'(bus.iss_valid), 64'd0);
        check("wake_t1_deq_ready", 64'(bus.deq_ready), 64'd1);
        tick();
        check("wake_t2_iss_valid", 64'(bus.iss_valid), 64'd1);
        check("wake_t2_iss_data", 64'(bus.iss_data), 64'(mk(6'h05, 1, 6'h07, 1, 6'h12, 32'h2222_0000)));

        // Double-source wakeup, invalid matching slot, and untouched pass-through data.
        clear_slots();
        e1 = mk(6'h09, 0, 6'h09, 0, 6'h13, 32'h3333_0001);
        e2 = mk(6'h09, 0, 6'h01, 1, 6'h14, 32'h3333_0002);
        bus.entry_valid    = 8'b0000_0010;
        bus.entry_douts[0] = mk(6'h09, 0, 6'h09, 0, 6'h15, 32'h3333_0000);
        bus.entry_douts[1] = e1;
        bus.entry_douts[2] = e2;
        bus.wb_valid       = 1'b1;
        bus.wb_tag         = 6'h09;
        #1;
        check("wake2_wr_en", 64'(bus.wr_en), 64'h02);
        check("wake2_wr_data1", 64'(bus.wr_data[1]), 64'(mk(6'h09, 1, 6'h09, 1, 6'h13, 32'h3333_0001)));
        check("wake2_wr_data2_pass", 64'(bus.wr_data[2]), 64'(e2));
        tick();
        check("wake2_drain", 64'(bus.iss_valid), 64'd0);

        // Blocked issue register: three stall cycles, then the oldest eligible slot.
        clear_slots();
        x_ent = mk(6'h20, 1, 6'h21, 1, 6'h16, 32'h4444_0000);
        bus.iss_ready      = 1'b0;
        bus.entry_valid    = 8'b0000_0001;
        bus.entry_douts[0] = x_ent;
        tick();
        check("stall_prefill", 64'(bus.iss_data), 64'(x_ent));
        e0 = mk(6'h22, 1, 6'h23, 1, 6'h17, 32'h4444_0001);
        e2 = mk(6'h24, 1, 6'h25, 1, 6'h18, 32'h4444_0002);
        bus.entry_valid    = 8'b0000_0101;
        bus.entry_douts[0] = e0;
        bus.entry_douts[2] = e2;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_deq_ready", 64'(bus.deq_ready), 64'd0);
            tick();
            check("stall_iss_data", 64'(bus.iss_data), 64'(x_ent));
            check("stall_iss_valid", 64'(bus.iss_valid), 64'd1);
        end
        check("stall_cnt_3", 64'(bus.stall_cnt), 64'd3);
        bus.iss_ready = 1'b1;
        #1;
        check("stall_release_sel", 64'(bus.deq_sel_onehot), 64'h01);
        tick();
        check("stall_release_data", 64'(bus.iss_data), 64'(e0));
        check("stall_cnt_hold", 64'(bus.stall_cnt), 64'd3);

        // Back-to-back: queue shifts after each dequeue, issue every cycle in order.
        for (int k = 0; k < 4; k++) q[k] = mk(6'(k), 1, 6'(k + 8), 1, 6'h19, 32'h5555_0000 + 32'(k));
        for (int k = 0; k < 4; k++) begin
            clear_slots();
            bus.entry_valid = 8'(4'b1111 >> k);
            for (int i = 0; i < 4 - k; i++) bus.entry_douts[i] = q[k + i];
            #1;
            check("b2b_sel", 64'(bus.deq_sel_onehot), 64'h01);
            tick();
            check("b2b_iss_valid", 64'(bus.iss_valid), 64'd1);
            check("b2b_iss_data", 64'(bus.iss_data), 64'(q[k]));
        end

        // All slots empty, broadcast still matching stale contents.
        clear_slots();
        bus.entry_douts[0] = mk(6'h2A, 0, 6'h2A, 1, 6'h1A, 32'h6666_0000);
        bus.wb_valid       = 1'b1;
        bus.wb_tag         = 6'h2A;
        #1;
        check("empty_deq_ready", 64'(bus.deq_ready), 64'd0);
        check("empty_wr_en", 64'(bus.wr_en), 64'd0);
        tick();
        check("empty_drain", 64'(bus.iss_valid), 64'd0);
        check("empty_data_hold", 64'(bus.iss_data), 64'(q[3]));

        // Flush with a held uop, eligible slots and a pending wakeup.
        clear_slots();
        bus.iss_ready      = 1'b0;
        bus.entry_valid    = 8'b0000_0001;
        bus.entry_douts[0] = x_ent;
        tick();
        bus.entry_valid    = 8'b0000_0111;
        bus.entry_douts[1] = e0;
        bus.entry_douts[2] = mk(6'h0B, 0, 6'h01, 1, 6'h1B, 32'h7777_0000);
        bus.wb_valid       = 1'b1;
        bus.wb_tag         = 6'h0B;
        bus.flush          = 1'b1;
        #1;
        check("flush_deq_ready", 64'(bus.deq_ready), 64'd0);
        check("flush_wr_en", 64'(bus.wr_en), 64'd0);
        tick();
        check("flush_iss_valid", 64'(bus.iss_valid), 64'd0);
        check("flush_no_stall", 64'(bus.stall_cnt), 64'd3);
        bus.flush = 1'b0;

        // Asynchronous reset mid-stream discards the held uop and the stall count.
        clear_slots();
        bus.entry_valid    = 8'b0000_0001;
        bus.entry_douts[0] = x_ent;
        tick();
        tick();
        check("pre_rst_stall", 64'(bus.stall_cnt), 64'd4);
        #2;
        rst_aL = 1'b0;
        #1;
        check("async_rst_iss_valid", 64'(bus.iss_valid), 64'd0);
        check("async_rst_stall", 64'(bus.stall_cnt), 64'd0);
        check("async_rst_deq", 64'(bus.deq_ready), 64'd0);
        tick();
        check("in_rst_iss_valid", 64'(bus.iss_valid), 64'd0);
        rst_aL = 1'b1;
        bus.iss_ready = 1'b1;
        #1;
        check("post_rst_no_early_issue", 64'(bus.iss_valid), 64'd0);
        tick();
        check("post_rst_first_issue", 64'(bus.iss_data), 64'(x_ent));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
